// File: rtl/lcb_rx_frame_parser_if.sv
// Byte-stream and qualified-command bundle for lcb_rx_frame_parser.
// Parser side (slave):
//   inputs  iValid, iData[7:0]
//   outputs oValid, oAddr[4:0], oCmd[7:0], oBcast, oErr, oErrCode[1:0], oBusy
//   outputs oFrameCnt[15:0], oErrCnt[15:0] (only with LCB_PARSER_STATS_EN)
// Master side is the mirror image: the UART byte source plus the command consumer.
interface lcb_rx_frame_parser_if;
    logic        iValid;
    logic [7:0]  iData;
    logic        oValid;
    logic [4:0]  oAddr;
    logic [7:0]  oCmd;
    logic        oBcast;
    logic        oErr;
    logic [1:0]  oErrCode;
    logic        oBusy;
`ifdef LCB_PARSER_STATS_EN
    logic [15:0] oFrameCnt;
    logic [15:0] oErrCnt;
`endif

    modport slave (
        input  iValid, iData,
        output oValid, oAddr, oCmd, oBcast, oErr, oErrCode, oBusy
`ifdef LCB_PARSER_STATS_EN
      , output oFrameCnt, oErrCnt
`endif
    );

    modport master (
        output iValid, iData,
        input  oValid, oAddr, oCmd, oBcast, oErr, oErrCode, oBusy
`ifdef LCB_PARSER_STATS_EN
      , input  oFrameCnt, oErrCnt
`endif
    );
endinterface

// File: rtl/lcb_rx_frame_parser.sv
// CFM request frame parser: assembles SYNC/ADDR/CMD/CHK byte frames from the
// UART receiver, qualifies address and checksum, and emits a one-cycle accept
// or error strobe. Inter-byte timeout aborts a stalled frame.
// Ports:
//   clk  - system clock (80 MHz)
//   rst  - asynchronous active-low reset
//   bus  - lcb_rx_frame_parser_if.slave: byte stream in, command/error out
// Optional: define LCB_PARSER_STATS_EN to add saturating 16-bit accept/error
// counters (bus.oFrameCnt, bus.oErrCnt).
module lcb_rx_frame_parser #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [4:0]  MY_ADDR     = 5'd3,
    parameter logic [7:0]  BCAST_ADDR  = 8'hFF,
    parameter int unsigned TIMEOUT_CYC = 8000
) (
    input  logic                  clk,
    input  logic                  rst,
    lcb_rx_frame_parser_if.slave  bus
);

    localparam int unsigned        CNT_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]         ERR_CHK  = 2'b01;
    localparam logic [1:0]         ERR_TO   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_CMD,
        S_CHK
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         rx_addr_q, rx_addr_d;
    logic [7:0]         rx_cmd_q, rx_cmd_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [4:0]         addr_q, addr_d;
    logic [7:0]         cmd_q, cmd_d;
    logic               bcast_q, bcast_d;

    // Next-state, timeout and frame qualification
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_addr_d  = rx_addr_q;
        rx_cmd_d   = rx_cmd_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        addr_d     = addr_q;
        cmd_d      = cmd_q;
        bcast_d    = bcast_q;

        // Counter only runs inside a frame; any byte restarts the window
        if (state_q == S_IDLE || bus.iValid) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.iValid && bus.iData == SYNC_BYTE) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus.iValid) begin
                    rx_addr_d = bus.iData;
                    state_d   = S_CMD;
                end
            end
            S_CMD: begin
                if (bus.iValid) begin
                    rx_cmd_d = bus.iData;
                    state_d  = S_CHK;
                end
            end
            S_CHK: begin
                if (bus.iValid) begin
                    state_d = S_IDLE;
                    if (bus.iData == (rx_addr_q ^ rx_cmd_q)) begin
                        if (rx_addr_q == {3'b000, MY_ADDR}) begin
                            valid_d = 1'b1;
                            addr_d  = MY_ADDR;
                            cmd_d   = rx_cmd_q;
                            bcast_d = 1'b0;
                        end else if (rx_addr_q == BCAST_ADDR) begin
                            valid_d = 1'b1;
                            addr_d  = 5'h1F;
                            cmd_d   = rx_cmd_q;
                            bcast_d = 1'b1;
                        end
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CHK;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A byte in the last allowed cycle wins over the timeout
        if (state_q != S_IDLE && !bus.iValid && cnt_q == CNT_LAST) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            err_d      = 1'b1;
            err_code_d = ERR_TO;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rx_addr_q  <= '0;
            rx_cmd_q   <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            addr_q     <= '0;
            cmd_q      <= '0;
            bcast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_addr_q  <= rx_addr_d;
            rx_cmd_q   <= rx_cmd_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            addr_q     <= addr_d;
            cmd_q      <= cmd_d;
            bcast_q    <= bcast_d;
        end
    end

    assign bus.oValid   = valid_q;
    assign bus.oAddr    = addr_q;
    assign bus.oCmd     = cmd_q;
    assign bus.oBcast   = bcast_q;
    assign bus.oErr     = err_q;
    assign bus.oErrCode = err_code_q;
    assign bus.oBusy    = (state_q != S_IDLE);

`ifdef LCB_PARSER_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] err_cnt_q;

    // Saturating accept/error counters, stepped alongside the strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (valid_d && frame_cnt_q != 16'hFFFF) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (err_d && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign bus.oFrameCnt = frame_cnt_q;
    assign bus.oErrCnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_lcb_rx_frame_parser.sv
// Scoreboard bench for lcb_rx_frame_parser: directed frames from the test plan
// followed by randomized frames, checked against a frame-level reference model.
module tb_lcb_rx_frame_parser;

    localparam int TO = 1000;

    logic clk;
    logic rst;
    int   cyc;

    lcb_rx_frame_parser_if bus ();

    lcb_rx_frame_parser #(
        .SYNC_BYTE   (8'hA5),
        .MY_ADDR     (5'd3),
        .BCAST_ADDR  (8'hFF),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [4:0] addr;
        logic [7:0] cmd;
        logic       bcast;
        logic [1:0] code;
        int         cyc;
    } exp_t;

    exp_t       expq[$];
    exp_t       e;
    logic [7:0] mframe[$];
    int         last_strobe;
    int         n_cmp;
    int         n_bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input bit is_err, input logic [4:0] a, input logic [7:0] c,
                                input logic b, input logic [1:0] code, input int at);
        exp_t x;
        x.is_err = is_err; x.addr = a; x.cmd = c; x.bcast = b; x.code = code; x.cyc = at;
        return x;
    endfunction

    // Model: a frame in progress that sees a gap longer than TO aborts at last_strobe+TO
    function automatic void model_advance(input int next_cyc);
        if (mframe.size() > 0 && next_cyc - last_strobe > TO) begin
            expq.push_back(mk(1'b1, 5'h0, 8'h0, 1'b0, 2'b10, last_strobe + TO));
            mframe.delete();
        end
    endfunction

    // Model: frame assembly and qualification at byte granularity
    function automatic void model_byte(input logic [7:0] b, input int at);
        logic [7:0] a, c, k;
        last_strobe = at;
        if (mframe.size() == 0) begin
            if (b == 8'hA5) mframe.push_back(b);
        end else begin
            mframe.push_back(b);
            if (mframe.size() == 4) begin
                a = mframe[1]; c = mframe[2]; k = mframe[3];
                if (k != (a ^ c))
                    expq.push_back(mk(1'b1, 5'h0, 8'h0, 1'b0, 2'b01, at));
                else if (a == 8'h03)
                    expq.push_back(mk(1'b0, 5'd3, c, 1'b0, 2'b00, at));
                else if (a == 8'hFF)
                    expq.push_back(mk(1'b0, 5'h1F, c, 1'b1, 2'b00, at));
                mframe.delete();
            end
        end
    endfunction

    // Send one byte whose strobe lands `gap` cycles after the current cycle
    task automatic send(input logic [7:0] b, input int gap);
        model_advance(cyc + gap);
        repeat (gap - 1) @(negedge clk);
        bus.iValid = 1'b1;
        bus.iData  = b;
        model_byte(b, cyc + 1);
        @(negedge clk);
        bus.iValid = 1'b0;
        bus.iData  = 8'h00;
    endtask

    task automatic idle(input int n);
        model_advance(cyc + n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int rgap();
        int x;
        x = int'($urandom_range(0, 39));
        if (x == 0) return TO + 1;
        if (x == 1) return TO;
        return int'($urandom_range(1, 12));
    endfunction

    // Monitor: every strobe is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst) begin
            if (expq.size() > 0 && cyc > expq[0].cyc) begin
                chk("missed_strobe_at", 32'(cyc), 32'(expq[0].cyc));
                void'(expq.pop_front());
            end
            if (bus.oValid || bus.oErr) begin
                if (expq.size() == 0) begin
                    chk("unexpected_strobe", {30'b0, bus.oValid, bus.oErr}, 32'h0);
                end else begin
                    e = expq.pop_front();
                    chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
                    chk("strobe_kind", {30'b0, bus.oValid, bus.oErr}, e.is_err ? 32'h1 : 32'h2);
                    if (e.is_err) begin
                        chk("err_code", 32'(bus.oErrCode), 32'(e.code));
                    end else begin
                        chk("acc_addr", 32'(bus.oAddr), 32'(e.addr));
                        chk("acc_cmd", 32'(bus.oCmd), 32'(e.cmd));
                        chk("acc_bcast", 32'(bus.oBcast), 32'(e.bcast));
                    end
                end
            end
        end
    end

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        last_strobe = 0;
        rst = 1'b0;
        bus.iValid = 1'b0;
        bus.iData  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {13'b0, bus.oValid, bus.oAddr, bus.oCmd, bus.oBcast,
                              bus.oErr, bus.oErrCode, bus.oBusy}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Own-address frame, widely spaced
        send(8'hA5, 5); send(8'h03, 800); send(8'h42, 800); send(8'h41, 800);
        idle(4);
        // Broadcast
        send(8'hA5, 3); send(8'hFF, 2); send(8'h10, 1); send(8'hEF, 4);
        idle(3);
        // Checksum error, then a back-to-back good frame
        send(8'hA5, 2); send(8'h03, 2); send(8'h42, 2); send(8'h00, 2);
        send(8'hA5, 1); send(8'h03, 1); send(8'h07, 1); send(8'h04, 1);
        idle(3);

        // Timeout after ADDR byte; oBusy drops with the error strobe
        send(8'hA5, 2); send(8'h03, 3);
        idle(TO - 1);
        chk("busy_before_timeout", 32'(bus.oBusy), 32'h1);
        idle(1);
        chk("busy_after_timeout", 32'(bus.oBusy), 32'h0);
        idle(5);

        // Garbage then foreign-address frame
        send(8'h11, 2); send(8'h22, 2);
        chk("busy_after_garbage", 32'(bus.oBusy), 32'h0);
        send(8'hA5, 2);
        chk("busy_after_sync", 32'(bus.oBusy), 32'h1);
        send(8'h05, 2); send(8'h01, 2);
        chk("busy_before_chk", 32'(bus.oBusy), 32'h1);
        send(8'h04, 2);
        chk("busy_after_foreign", 32'(bus.oBusy), 32'h0);
        idle(3);

        // Bytes exactly on the last allowed cycle, then one cycle too late
        send(8'hA5, 2); send(8'h03, TO); send(8'h42, TO); send(8'h41, TO);
        idle(2);
        send(8'hA5, 2); send(8'h03, TO + 1);
        idle(4);

        // Async reset in the middle of CMD
        send(8'hA5, 2); send(8'h03, 2);
        #3 rst = 1'b0;
        #1;
        chk("midframe_reset_outputs", {13'b0, bus.oValid, bus.oAddr, bus.oCmd, bus.oBcast,
                                       bus.oErr, bus.oErrCode, bus.oBusy}, 32'h0);
        mframe.delete();
        chk("no_pending_at_reset", 32'(expq.size()), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        send(8'h42, 2); send(8'h41, 2);   // tail of lost frame: ignored in IDLE
        idle(2);

        // Randomized frames
        for (int i = 0; i < 60; i++) begin
            logic [7:0] a, c, k;
            int sel;
            if ($urandom_range(0, 4) == 0) send(8'($urandom), rgap());
            sel = int'($urandom_range(0, 3));
            a = (sel < 2) ? 8'h03 : (sel == 2) ? 8'hFF : 8'($urandom);
            c = 8'($urandom);
            k = a ^ c;
            if ($urandom_range(0, 3) == 0) k = k ^ 8'($urandom_range(1, 255));
            send(8'hA5, rgap()); send(a, rgap()); send(c, rgap()); send(k, rgap());
        end

        idle(TO + 10);
        chk("scoreboard_drained", 32'(expq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
